// File: rtl/svm_stream_feeder_if.sv
// SVM-side bus of the stream feeder: model/feature payload plus the fin and dout handshakes.
// The master modport is the feeder and the slave modport is the SVM classifier.
interface svm_stream_feeder_if #(
    parameter int unsigned NBITS     = 9,
    parameter int unsigned SUP_WIDTH = 155,
    parameter int unsigned F_WIDTH   = 214,
    parameter int unsigned IW        = 26
);
    logic [NBITS*F_WIDTH-1:0]           svm_features;
    logic [NBITS*SUP_WIDTH*F_WIDTH-1:0] svm_support;
    logic [NBITS*SUP_WIDTH-1:0]         svm_alpha;
    logic [IW-1:0]                      svm_intercept;
    logic                               svm_fin_valid;
    logic                               svm_fin_ready;
    logic                               svm_valence;
    logic                               svm_arousal;
    logic                               svm_dout_valid;
    logic                               svm_dout_ready;

    modport master (
        output svm_features,
        output svm_support,
        output svm_alpha,
        output svm_intercept,
        output svm_fin_valid,
        output svm_dout_ready,
        input  svm_fin_ready,
        input  svm_valence,
        input  svm_arousal,
        input  svm_dout_valid
    );

    modport slave (
        input  svm_features,
        input  svm_support,
        input  svm_alpha,
        input  svm_intercept,
        input  svm_fin_valid,
        input  svm_dout_ready,
        output svm_fin_ready,
        output svm_valence,
        output svm_arousal,
        output svm_dout_valid
    );
endinterface

// File: rtl/svm_stream_feeder.sv
// Feeds each feature frame to the SVM twice (valence model, then arousal model) and returns
// the captured result downstream. SVM_FEEDER_TIMEOUT_EN adds a result watchdog and err_timeout.
module svm_stream_feeder #(
    parameter int unsigned NBITS         = 9,
    parameter int unsigned VSUP_WIDTH    = 120,
    parameter int unsigned ASUP_WIDTH    = 155,
    parameter int unsigned F_WIDTH       = 214,
    parameter int unsigned SUP_WIDTH     = (VSUP_WIDTH > ASUP_WIDTH) ? VSUP_WIDTH : ASUP_WIDTH,
    parameter int unsigned LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
    parameter int unsigned IW            = 2 * NBITS + LOG_SUP_WIDTH,
    parameter int unsigned CADDR_W       = $clog2(SUP_WIDTH * F_WIDTH)
`ifdef SVM_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBITS*F_WIDTH-1:0] feat_in,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_sel,
    input  logic [CADDR_W-1:0]       cfg_addr,
    input  logic [IW-1:0]            cfg_data,
    output logic                     cfg_ready,
    svm_stream_feeder_if.master      svm,
    output logic                     out_valence,
    output logic                     out_arousal,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef SVM_FEEDER_TIMEOUT_EN
    output logic                     err_timeout,
`endif
    output logic                     busy
);

    localparam int unsigned VSUP_N = VSUP_WIDTH * F_WIDTH;
    localparam int unsigned ASUP_N = ASUP_WIDTH * F_WIDTH;
    localparam int unsigned VS_AW  = (VSUP_N > 1) ? $clog2(VSUP_N) : 1;
    localparam int unsigned AS_AW  = (ASUP_N > 1) ? $clog2(ASUP_N) : 1;
    localparam int unsigned VA_AW  = (VSUP_WIDTH > 1) ? $clog2(VSUP_WIDTH) : 1;
    localparam int unsigned AA_AW  = (ASUP_WIDTH > 1) ? $clog2(ASUP_WIDTH) : 1;
    localparam int unsigned SUPBUS = NBITS * SUP_WIDTH * F_WIDTH;

    typedef enum logic [2:0] {StIdle, StSendV, StSendA, StWaitRes, StHold} state_e;

    state_e state_q, state_d;

    // Model register files: written only from the config port, never reset.
    logic [NBITS-1:0] v_sup_q   [VSUP_N];
    logic [NBITS-1:0] a_sup_q   [ASUP_N];
    logic [NBITS-1:0] v_alpha_q [VSUP_WIDTH];
    logic [NBITS-1:0] a_alpha_q [ASUP_WIDTH];
    logic [IW-1:0]    v_icpt_q;
    logic [IW-1:0]    a_icpt_q;

    logic [SUPBUS-1:0]          v_sup_flat, a_sup_flat;
    logic [NBITS*SUP_WIDTH-1:0] v_alpha_flat, a_alpha_flat;

    logic [NBITS*F_WIDTH-1:0]   features_q;
    logic [SUPBUS-1:0]          sup_q;
    logic [NBITS*SUP_WIDTH-1:0] alpha_q;
    logic [IW-1:0]              icpt_q;

    logic out_valence_q, out_arousal_q, out_valid_q;
    logic cfg_ok, accept, v_fire, a_fire, res_fire, out_fire, abort;

    assign cfg_ready  = (state_q == StIdle);
    assign feat_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign cfg_ok     = cfg_we && cfg_ready;
    assign accept     = feat_valid && feat_ready;
    assign v_fire     = (state_q == StSendV) && svm.svm_fin_ready;
    assign a_fire     = (state_q == StSendA) && svm.svm_fin_ready;
    assign res_fire   = (state_q == StWaitRes) && svm.svm_dout_valid;
    assign out_fire   = out_valid_q && out_ready;

`ifdef SVM_FEEDER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit, err_q;

    // The watchdog only aborts if the pending handshake did not complete this cycle.
    assign tmo_hit = ((state_q == StSendA) || (state_q == StWaitRes)) &&
                     (32'(tmo_cnt_q) >= TIMEOUT_CYCLES - 1);
    assign abort   = tmo_hit && !a_fire && !res_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if ((state_d != state_q) && ((state_d == StSendA) || (state_d == StWaitRes))) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == StSendA) || (state_q == StWaitRes)) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end else if (cfg_ok && (cfg_sel == 3'd7)) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            case (cfg_sel)
                3'd0: if (32'(cfg_addr) < VSUP_N) v_sup_q[cfg_addr[VS_AW-1:0]] <= cfg_data[NBITS-1:0];
                3'd1: if (32'(cfg_addr) < VSUP_WIDTH)
                          v_alpha_q[cfg_addr[VA_AW-1:0]] <= cfg_data[NBITS-1:0];
                3'd2: v_icpt_q <= cfg_data;
                3'd3: if (32'(cfg_addr) < ASUP_N) a_sup_q[cfg_addr[AS_AW-1:0]] <= cfg_data[NBITS-1:0];
                3'd4: if (32'(cfg_addr) < ASUP_WIDTH)
                          a_alpha_q[cfg_addr[AA_AW-1:0]] <= cfg_data[NBITS-1:0];
                3'd5: a_icpt_q <= cfg_data;
                default: ;
            endcase
        end
    end

    // Storage index row*F_WIDTH+col matches the bus layout, so rows past the model stay zero.
    always_comb begin
        v_sup_flat   = '0;
        a_sup_flat   = '0;
        v_alpha_flat = '0;
        a_alpha_flat = '0;
        for (int i = 0; i < VSUP_N; i++) v_sup_flat[i*NBITS +: NBITS] = v_sup_q[i];
        for (int i = 0; i < ASUP_N; i++) a_sup_flat[i*NBITS +: NBITS] = a_sup_q[i];
        for (int i = 0; i < VSUP_WIDTH; i++) v_alpha_flat[i*NBITS +: NBITS] = v_alpha_q[i];
        for (int i = 0; i < ASUP_WIDTH; i++) a_alpha_flat[i*NBITS +: NBITS] = a_alpha_q[i];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            features_q <= feat_in;
            sup_q      <= v_sup_flat;
            alpha_q    <= v_alpha_flat;
            icpt_q     <= v_icpt_q;
        end else if (v_fire) begin
            sup_q   <= a_sup_flat;
            alpha_q <= a_alpha_flat;
            icpt_q  <= a_icpt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (feat_valid) state_d = StSendV;
            StSendV:   if (svm.svm_fin_ready) state_d = StSendA;
            StSendA: begin
                if (svm.svm_fin_ready) state_d = StWaitRes;
                else if (abort) state_d = StIdle;
            end
            StWaitRes: begin
                if (svm.svm_dout_valid) state_d = StHold;
                else if (abort) state_d = StIdle;
            end
            StHold:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            out_valence_q <= 1'b0;
            out_arousal_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (res_fire) begin
                out_valence_q <= svm.svm_valence;
                out_arousal_q <= svm.svm_arousal;
                out_valid_q   <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign svm.svm_features   = features_q;
    assign svm.svm_support    = sup_q;
    assign svm.svm_alpha      = alpha_q;
    assign svm.svm_intercept  = icpt_q;
    assign svm.svm_fin_valid  = (state_q == StSendV) || (state_q == StSendA);
    assign svm.svm_dout_ready = 1'b1;

    assign out_valence = out_valence_q;
    assign out_arousal = out_arousal_q;
    assign out_valid   = out_valid_q;

endmodule
